fifo_ctrl: RTL and testbench

//   Synchronous FIFO controller for the push/pop data buffer. It sequences a DEPTH-entry storage array:
//   - push/pop acceptance
//   - wrapping write/read pointers
//   - occupancy count da_cnt, plus full/empty and almost-full/almost-empty flags
//   - sticky overflow/underflow error flags
//   It sits between the producer (push/da_in) and the consumer (pop/da_out).

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 50 +++++
 rtl/fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO controller slice: the occupancy state
//   codes and the default data width / depth.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MID   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_W register array. One synchronous write port and one
//   registered read port. When the same address is written and read in the
//   same cycle, the read returns the old contents.
// Ports
//   clk    in   rising-edge clock
//   rst    in   async active-high reset (read register only; array is not reset)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds when low
//   raddr  in   read address
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read stage: nonblocking semantics give read-before-write on a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Synchronous FIFO controller: push/pop acceptance, wrapping pointers,
//   occupancy count, full/empty/almost flags and sticky error flags around a
//   single fifo_mem instance.
// Ports
//   clk      in   rising-edge clock
//   rst      in   async active-high reset
//   push     in   write request; da_in sampled when accepted
//   da_in    in   write data
//   pop      in   read request
//   clr_err  in   synchronous clear of ovf/udf
//   da_out   out  registered read data
//   da_vld   out  1-cycle pulse, da_out holds a newly popped word
//   da_cnt   out  occupancy 0..DEPTH
//   full     out  da_cnt == DEPTH
//   empty    out  da_cnt == 0
//   afull    out  da_cnt >= AF_LVL
//   aempty   out  da_cnt <= AE_LVL
//   ovf      out  sticky: a push was rejected
//   udf      out  sticky: a pop was rejected
// ---------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] da_in,
  input  logic              pop,
  input  logic              clr_err,
  output logic [DATA_W-1:0] da_out,
  output logic              da_vld,
  output logic [CNT_W-1:0]  da_cnt,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LVL);

  occ_e             occ;
  occ_e             occ_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push_acc;
  logic             pop_acc;
  logic             vld_p1;

  // Acceptance stage: decided from registered state only.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Explicit wrap so non-power-of-2 depths work.
  assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
  assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);

  always_comb begin
    cnt_nxt = da_cnt;
    case ({push_acc, pop_acc})
      2'b10:   cnt_nxt = da_cnt + CNT_W'(1);
      2'b01:   cnt_nxt = da_cnt - CNT_W'(1);
      default: cnt_nxt = da_cnt;
    endcase
  end

  always_comb begin
    occ_nxt = occ;
    case (occ)
      OCC_EMPTY: begin
        if (push_acc && !pop_acc) occ_nxt = OCC_MID;
      end
      OCC_MID: begin
        if (pop_acc && !push_acc && da_cnt == CNT_ONE) begin
          occ_nxt = OCC_EMPTY;
        end else if (push_acc && !pop_acc && da_cnt == CNT_LAST) begin
          occ_nxt = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (pop_acc && !push_acc) occ_nxt = OCC_MID;
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= OCC_EMPTY;
    end else begin
      occ <= occ_nxt;
    end
  end

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == OCC_EMPTY);

  // Register stage: pointers, count, almost flags (from next count), errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      da_cnt <= '0;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr_nxt;
      if (pop_acc)  rd_ptr <= rd_ptr_nxt;
      da_cnt <= cnt_nxt;
      afull  <= (cnt_nxt >= CNT_AF);
      aempty <= (cnt_nxt <= CNT_AE);
      // A fresh error in the clearing cycle keeps the flag set.
      ovf    <= (push & ~push_acc) | (ovf & ~clr_err);
      udf    <= (pop & ~pop_acc) | (udf & ~clr_err);
      vld_p1 <= pop_acc;
    end
  end

  assign da_vld = vld_p1;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (da_in),
    .re    (pop_acc),
    .raddr (rd_ptr),
    .rdata (da_out)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [3:0] da_in;
  logic       pop;
  logic       clr_err;
  logic [3:0] da_out;
  logic       da_vld;
  logic [2:0] da_cnt;
  logic       full, empty, afull, aempty, ovf, udf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] sb_q [$];

  fifo_ctrl #(
    .DATA_W (4),
    .DEPTH  (4),
    .AF_LVL (3),
    .AE_LVL (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .da_in   (da_in),
    .pop     (pop),
    .clr_err (clr_err),
    .da_out  (da_out),
    .da_vld  (da_vld),
    .da_cnt  (da_cnt),
    .full    (full),
    .empty   (empty),
    .afull   (afull),
    .aempty  (aempty),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every da_vld pulse must match the oldest expected read word.
  always @(negedge clk) begin
    if (da_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_vld: got da_out 0x%0h, expected no output at %0t", da_out, $time);
      end else begin
        check("da_out", {28'd0, da_out}, {28'd0, sb_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic p, input logic [3:0] d, input logic q, input logic c,
                      input logic has_exp, input logic [3:0] exp_d);
    push = p; da_in = d; pop = q; clr_err = c;
    if (has_exp) sb_q.push_back(exp_d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic f, input logic e,
                           input logic af, input logic ae);
    check({tag, "_cnt"},    {29'd0, da_cnt}, cnt);
    check({tag, "_full"},   {31'd0, full},   {31'd0, f});
    check({tag, "_empty"},  {31'd0, empty},  {31'd0, e});
    check({tag, "_afull"},  {31'd0, afull},  {31'd0, af});
    check({tag, "_aempty"}, {31'd0, aempty}, {31'd0, ae});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; da_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1 reset state
    chk_state("rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_vld", {31'd0, da_vld}, 0);
    check("rst_out", {28'd0, da_out}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_udf", {31'd0, udf}, 0);

    // 2 fill to overflow
    step(1, 4'h1, 0, 0, 0, 4'h0);
    chk_state("fill1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 4'h2, 0, 0, 0, 4'h0);
    chk_state("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, 4'h3, 0, 0, 0, 4'h0);
    chk_state("fill3", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1, 4'h4, 0, 0, 0, 4'h0);
    chk_state("fill4", 4, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fill4_ovf", {31'd0, ovf}, 0);
    step(1, 4'h5, 0, 0, 0, 4'h0);
    chk_state("ovf", 4, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ovf_set", {31'd0, ovf}, 1);
    step(0, 4'h0, 0, 1, 0, 4'h0);
    check("ovf_clr", {31'd0, ovf}, 0);

    // 3 drain to underflow (0x5 must not appear)
    for (int i = 1; i <= 4; i++) begin
      step(0, 4'h0, 1, 0, 1, 4'(i));
      check("drain_vld", {31'd0, da_vld}, 1);
      check("drain_cnt", {29'd0, da_cnt}, 4 - i);
    end
    chk_state("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(0, 4'h0, 1, 0, 0, 4'h0);
    check("udf_set", {31'd0, udf}, 1);
    check("udf_vld", {31'd0, da_vld}, 0);
    check("udf_cnt", {29'd0, da_cnt}, 0);
    step(0, 4'h0, 0, 1, 0, 4'h0);
    check("udf_clr", {31'd0, udf}, 0);

    // 4 full with push+pop together, then wrap
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0, 4'h0);
    step(1, 4'h9, 1, 0, 1, 4'h1);
    chk_state("pp_full", 4, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pp_full_ovf", {31'd0, ovf}, 0);
    check("pp_full_vld", {31'd0, da_vld}, 1);
    step(0, 4'h0, 1, 0, 1, 4'h2);
    step(0, 4'h0, 1, 0, 1, 4'h3);
    step(0, 4'h0, 1, 0, 1, 4'h4);
    step(0, 4'h0, 1, 0, 1, 4'h9);
    chk_state("wrap_done", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 5 empty with push+pop together: push wins, pop rejected
    step(1, 4'h7, 1, 0, 0, 4'h0);
    check("pp_empty_udf", {31'd0, udf}, 1);
    check("pp_empty_vld", {31'd0, da_vld}, 0);
    check("pp_empty_cnt", {29'd0, da_cnt}, 1);
    step(0, 4'h0, 0, 1, 0, 4'h0);
    check("pp_empty_clr", {31'd0, udf}, 0);
    step(0, 4'h0, 1, 0, 1, 4'h7);
    check("pop7_cnt", {29'd0, da_cnt}, 0);
    // fresh underflow in the clearing cycle keeps udf set
    step(0, 4'h0, 1, 1, 0, 4'h0);
    check("clr_vs_err", {31'd0, udf}, 1);
    step(0, 4'h0, 0, 1, 0, 4'h0);
    check("clr_again", {31'd0, udf}, 0);

    // 6 asynchronous reset mid-cycle at count 2
    step(1, 4'hB, 0, 0, 0, 4'h0);
    step(1, 4'hC, 0, 0, 0, 4'h0);
    step(1, 4'hD, 0, 0, 0, 4'h0);
    step(0, 4'h0, 1, 0, 0, 4'h0);
    check("pre_rst_out", {28'd0, da_out}, 32'hB);
    check("pre_rst_vld", {31'd0, da_vld}, 1);
    check("pre_rst_cnt", {29'd0, da_cnt}, 2);
    #1 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("async_rst_vld", {31'd0, da_vld}, 0);
    check("async_rst_out", {28'd0, da_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 4'hA, 0, 0, 0, 4'h0);
    step(0, 4'h0, 1, 0, 1, 4'hA);
    chk_state("post_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
